axis_video_out: RTL

- AXI4-Stream video master at the output end of the projection path.
- Accepts a ready/valid pixel stream from barrel_projection_wrapper and buffers it in a small FIFO.
- Emits AXIS beats toward the VDMA/video-out. Adds tuser (start of frame) on pixel (0,0) and tlast (end of line) on the last pixel of each line.
- Reports frame completion and FIFO occupancy.

---
 rtl/axis_video_out.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_video_out.sv
// AXI4-Stream video master: pixel FIFO with a registered output head, raster tuser/tlast and frame_done.
// Optional PIX_SOF_RESYNC_EN: carry pix_sof through the FIFO and realign the raster counters to it.
module axis_video_out #(
    parameter int WIDTH      = 1080,
    parameter int HEIGHT     = 960,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             pix_data,
    input  logic                          pix_vld,
    output logic                          pix_rdy,
    input  logic                          pix_sof,
    output logic [DATA_W-1:0]             AXIS_Out_tdata,
    output logic                          AXIS_Out_tvalid,
    input  logic                          AXIS_Out_tready,
    output logic                          AXIS_Out_tuser,
    output logic                          AXIS_Out_tlast,
    output logic                          frame_done,
`ifdef PIX_SOF_RESYNC_EN
    output logic [15:0]                   sof_err_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
`ifdef PIX_SOF_RESYNC_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XW-1:0]     x_q, x_d, x_n;
    logic [YW-1:0]     y_q, y_d, y_n;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic              frame_done_q, frame_done_d;
    logic              push, pop, load;
    logic [EW-1:0]     wr_entry, rd_entry;
`ifdef PIX_SOF_RESYNC_EN
    logic [15:0]       err_q, err_d;
    assign wr_entry    = {pix_sof, pix_data};
    assign sof_err_cnt = err_q;
`else
    logic              unused_sof;
    assign unused_sof = pix_sof;
    assign wr_entry   = pix_data;
`endif

    // The count includes the beat sitting in the output head, so FIFO_DEPTH is the total capacity.
    assign pix_rdy = reset && (count_q < CW'(FIFO_DEPTH));
    assign push    = pix_vld && pix_rdy;
    assign pop     = tvalid_q && AXIS_Out_tready;

    assign AXIS_Out_tdata  = tdata_q;
    assign AXIS_Out_tvalid = tvalid_q;
    assign AXIS_Out_tuser  = tuser_q;
    assign AXIS_Out_tlast  = tlast_q;
    assign frame_done      = frame_done_q;
    assign fifo_level      = count_q;

    always_comb begin
        x_n = x_q;
        y_n = y_q;
        if (pop) begin
            if (x_q == X_LAST) begin
                x_n = '0;
                y_n = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_n = x_q + XW'(1);
            end
        end
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        load     = (!tvalid_q || pop) && (count_d != '0);
        // Nothing older left in memory: the head takes the pixel being pushed this cycle.
        rd_entry = (count_q == CW'(pop)) ? wr_entry : mem_q[rd_ptr_d];

        x_d          = x_n;
        y_d          = y_n;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        tvalid_d     = (count_d != '0);
        frame_done_d = pop && (x_q == X_LAST) && (y_q == Y_LAST);
`ifdef PIX_SOF_RESYNC_EN
        err_d = err_q;
`endif
        if (load) begin
            tdata_d = rd_entry[DATA_W-1:0];
            tuser_d = (x_n == '0) && (y_n == '0);
            tlast_d = (x_n == X_LAST);
`ifdef PIX_SOF_RESYNC_EN
            if (rd_entry[DATA_W] && !tuser_d) begin
                tuser_d = 1'b1;
                tlast_d = (X_LAST == '0);
                x_d     = '0;
                y_d     = '0;
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PIX_SOF_RESYNC_EN
            err_q        <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
`ifdef PIX_SOF_RESYNC_EN
            err_q        <= err_d;
`endif
        end
    end
endmodule
